vga_frame_fetcher: RTL and testbench

//  Frame-buffer read scheduler between the SDRAM read port and VGA_Controller. Prefetches RGB565

---
 rtl/vga_frame_fetcher.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_frame_fetcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_fetcher.sv
// Frame-buffer read scheduler: prefetches RGB565 bursts from SDRAM into a pixel FIFO
// and pops one expanded 30-bit pixel per VGA request, rewinding on each vsync fall.
module vga_frame_fetcher #(
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 32,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iVGA_V_SYNC,
  input  logic              iPix_Req,
  output logic [9:0]        oRed,
  output logic [9:0]        oGreen,
  output logic [9:0]        oBlue,
  output logic              oRd_Req,
  output logic [ADDR_W-1:0] oRd_Addr,
  input  logic              iRd_Gnt,
  input  logic              iRd_Valid,
  input  logic [15:0]       iRd_Data,
  output logic              oUnderflow,
  output logic              oFrame_Done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int WCNT_W = $clog2(FRAME_WORDS + 1);

  localparam logic [CNT_W-1:0]  FILL_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [WCNT_W-1:0] WORDS_END  = WCNT_W'(FRAME_WORDS);
  localparam logic [WCNT_W-1:0] WORDS_STEP = WCNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_BASE  = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_WAIT_VS  = 3'd0,
    S_FILL_CHK = 3'd1,
    S_REQ      = 3'd2,
    S_BURST    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // RGB565 to 10-bit-per-channel by replicating the MSBs into the low bits.
  function automatic logic [29:0] expand565(input logic [15:0] w);
    expand565 = {w[15:11], w[15:11], w[10:5], w[10:7], w[4:0], w[4:0]};
  endfunction

  state_t              state_q, state_d;
  logic                vs_q;
  logic                discard_q, discard_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WCNT_W-1:0]   issued_q, issued_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [29:0]         rgb_q, rgb_d;
  logic                underflow_q, underflow_d;
  logic                frame_done_q, frame_done_d;
  logic                rd_req_q, rd_req_d;
  logic [15:0]         mem_q [FIFO_DEPTH];

  logic                vs_fall_s;
  logic                rewind_s;
  logic                discard_now_s;
  logic                wr_en_s;
  logic                rd_en_s;

  assign vs_fall_s = vs_q & ~iVGA_V_SYNC;

  // Fetch scheduler: decides when to request, tracks burst beats and frame rewinds.
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    addr_d        = addr_q;
    issued_d      = issued_q;
    beat_d        = beat_q;
    rewind_s      = 1'b0;
    discard_now_s = 1'b0;
    wr_en_s       = 1'b0;
    case (state_q)
      S_WAIT_VS: begin
        if (vs_fall_s) begin
          rewind_s = 1'b1;
          state_d  = S_FILL_CHK;
        end else begin
          state_d  = S_WAIT_VS;
        end
      end
      S_FILL_CHK: begin
        if (vs_fall_s) begin
          rewind_s = 1'b1;
          state_d  = S_FILL_CHK;
        end else if (issued_q == WORDS_END) begin
          state_d  = S_DONE;
        end else if (count_q <= FILL_LIMIT) begin
          state_d  = S_REQ;
        end else begin
          state_d  = S_FILL_CHK;
        end
      end
      S_REQ: begin
        // A grant coinciding with the vsync edge still obliges us to absorb the burst.
        if (iRd_Gnt) begin
          addr_d    = addr_q + ADDR_STEP;
          issued_d  = issued_q + WORDS_STEP;
          beat_d    = {BEAT_W{1'b0}};
          discard_d = vs_fall_s;
          state_d   = S_BURST;
        end else if (vs_fall_s) begin
          rewind_s  = 1'b1;
          state_d   = S_FILL_CHK;
        end else begin
          state_d   = S_REQ;
        end
      end
      S_BURST: begin
        discard_now_s = discard_q | vs_fall_s;
        if (iRd_Valid) begin
          beat_d  = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
          wr_en_s = ~discard_now_s;
          if (beat_q == BEAT_LAST) begin
            discard_d = 1'b0;
            if (discard_now_s) begin
              rewind_s = 1'b1;
              state_d  = S_FILL_CHK;
            end else if (issued_q == WORDS_END) begin
              state_d  = S_DONE;
            end else begin
              state_d  = S_FILL_CHK;
            end
          end else begin
            discard_d = discard_now_s;
          end
        end else begin
          discard_d = discard_now_s;
        end
      end
      S_DONE: begin
        if (vs_fall_s) begin
          rewind_s = 1'b1;
          state_d  = S_FILL_CHK;
        end else begin
          state_d  = S_WAIT_VS;
        end
      end
      default: begin
        state_d = S_WAIT_VS;
      end
    endcase
    addr_d       = rewind_s ? ADDR_BASE : addr_d;
    issued_d     = rewind_s ? {WCNT_W{1'b0}} : issued_d;
    rd_req_d     = (state_d == S_REQ);
    frame_done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // Pixel FIFO bookkeeping and the pop/expand path toward the VGA controller.
  always_comb begin
    rd_en_s     = 1'b0;
    rgb_d       = rgb_q;
    underflow_d = underflow_q;
    if (iPix_Req) begin
      if (rewind_s || discard_now_s) begin
        rgb_d = 30'd0;
      end else if (count_q != {CNT_W{1'b0}}) begin
        rgb_d   = expand565(mem_q[rd_ptr_q]);
        rd_en_s = 1'b1;
      end else begin
        rgb_d       = 30'd0;
        underflow_d = 1'b1;
      end
    end else begin
      rgb_d = rgb_q;
    end
    if (rewind_s) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_s);
      count_d  = count_q + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_WAIT_VS;
      vs_q         <= 1'b1;
      discard_q    <= 1'b0;
      addr_q       <= ADDR_BASE;
      issued_q     <= {WCNT_W{1'b0}};
      beat_q       <= {BEAT_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      rgb_q        <= 30'd0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rd_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= iVGA_V_SYNC;
      discard_q    <= discard_d;
      addr_q       <= addr_d;
      issued_q     <= issued_d;
      beat_q       <= beat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rgb_q        <= rgb_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      rd_req_q     <= rd_req_d;
    end
  end

  // Pixel storage; contents are only meaningful between the pointers.
  always_ff @(posedge iCLK) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= iRd_Data;
    end
  end

  assign oRed        = rgb_q[29:20];
  assign oGreen      = rgb_q[19:10];
  assign oBlue       = rgb_q[9:0];
  assign oRd_Req     = rd_req_q;
  assign oRd_Addr    = addr_q;
  assign oUnderflow  = underflow_q;
  assign oFrame_Done = frame_done_q;

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// Scoreboard bench for vga_frame_fetcher in a reduced 64-word frame configuration.
module tb_vga_frame_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic        pix_req;
  logic        gnt;
  logic        valid;
  logic [15:0] data;
  logic [9:0]  o_red, o_green, o_blue;
  logic        o_rd_req;
  logic [21:0] o_rd_addr;
  logic        o_underflow;
  logic        o_frame_done;

  int errors = 0;
  int checks = 0;
  logic [29:0] sb[$];
  logic [15:0] mq[$];
  logic [15:0] wbuf[8];

  vga_frame_fetcher #(
    .ADDR_W(22), .BURST_LEN(8), .FIFO_DEPTH(32), .FRAME_BASE(0), .FRAME_WORDS(64)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iVGA_V_SYNC(vs), .iPix_Req(pix_req),
    .oRed(o_red), .oGreen(o_green), .oBlue(o_blue),
    .oRd_Req(o_rd_req), .oRd_Addr(o_rd_addr), .iRd_Gnt(gnt),
    .iRd_Valid(valid), .iRd_Data(data),
    .oUnderflow(o_underflow), .oFrame_Done(o_frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] exp565(input logic [15:0] w);
    exp565 = {w[15:11], w[15:11], w[10:5], w[10:7], w[4:0], w[4:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each cycle after a sampled pop, compare RGB against the scoreboard head.
  initial begin
    logic seen;
    logic [29:0] e;
    forever begin
      @(posedge clk);
      seen = pix_req;
      @(negedge clk);
      if (seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: got %0h expected no pop", {o_red, o_green, o_blue});
        end else begin
          e = sb.pop_front();
          chk("pix_rgb", 32'({o_red, o_green, o_blue}), 32'(e));
        end
      end
    end
  end

  task automatic pop_model();
    if (mq.size() > 0) sb.push_back(exp565(mq.pop_front()));
    else sb.push_back(30'd0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      pop_model();
      pix_req = 1'b1;
      tick();
    end
    pix_req = 1'b0;
  endtask

  task automatic pop_hand(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    void'(mq.pop_front());
    sb.push_back({r, g, b});
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
  endtask

  task automatic pop_zero();
    sb.push_back(30'd0);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
  endtask

  task automatic wait_req(input logic [21:0] exp_addr, input string name);
    int n = 0;
    while (!o_rd_req && n < 60) begin
      tick();
      n++;
    end
    if (!o_rd_req) begin
      checks++;
      errors++;
      $display("FAIL %s: got no oRd_Req within 60 cycles expected request", name);
    end else begin
      chk(name, 32'(o_rd_addr), 32'(exp_addr));
    end
  endtask

  task automatic grant(input int delay);
    repeat (delay) tick();
    chk("req_held", 32'(o_rd_req), 32'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("req_drop", 32'(o_rd_req), 32'd0);
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < 8; i++) wbuf[i] = base + 16'(i);
  endtask

  task automatic send(input bit pop_each, input bit last);
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      data  = wbuf[i];
      if (pop_each) begin
        pop_model();
        pix_req = 1'b1;
      end
      chk("no_overflow", 32'(mq.size() < 32), 32'd1);
      mq.push_back(wbuf[i]);
      tick();
    end
    valid   = 1'b0;
    pix_req = 1'b0;
    chk("frame_done_at_burst_end", 32'(o_frame_done), 32'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vs = 1'b1; pix_req = 1'b0; gnt = 1'b0; valid = 1'b0; data = 16'h0000;
    repeat (3) tick();
    chk("rst_req", 32'(o_rd_req), 32'd0);
    chk("rst_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_rgb", 32'({o_red, o_green, o_blue}), 32'd0);
    chk("rst_underflow", 32'(o_underflow), 32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_no_req", 32'(o_rd_req), 32'd0);

    // Frame 1: fill FIFO with four bursts, then the fifth waits for space.
    vs = 1'b0; tick(); vs = 1'b1;
    wait_req(22'd0, "addr_b0");
    grant(3);
    wbuf = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000, 16'h8410, 16'h1234, 16'hABCD};
    send(1'b0, 1'b0);
    wait_req(22'd8, "addr_b1");  grant(3); fill(16'h1100); send(1'b0, 1'b0);
    wait_req(22'd16, "addr_b2"); grant(1); fill(16'h1200); send(1'b0, 1'b0);
    wait_req(22'd24, "addr_b3"); grant(2); fill(16'h1300); send(1'b0, 1'b0);
    repeat (10) tick();
    chk("withhold_full", 32'(o_rd_req), 32'd0);
    pop_hand(10'h3FF, 10'h000, 10'h000);
    pop_hand(10'h000, 10'h3FF, 10'h000);
    pop_hand(10'h000, 10'h000, 10'h3FF);
    repeat (3) tick();
    chk("rgb_hold", 32'({o_red, o_green, o_blue}), 32'h0000_03FF);
    pop_n(4);
    repeat (3) tick();
    chk("withhold_7_popped", 32'(o_rd_req), 32'd0);
    pop_n(1);
    wait_req(22'd32, "addr_b4"); grant(3); fill(16'h1400); send(1'b1, 1'b0);
    wait_req(22'd40, "addr_b5"); grant(3); fill(16'h1500); send(1'b0, 1'b0);
    pop_n(8);
    wait_req(22'd48, "addr_b6"); grant(2); fill(16'h1600); send(1'b0, 1'b0);
    pop_n(8);
    wait_req(22'd56, "addr_b7"); grant(2); fill(16'h1700); send(1'b0, 1'b1);
    tick();
    chk("frame_done_pulse_end", 32'(o_frame_done), 32'd0);
    repeat (10) tick();
    chk("no_req_after_done", 32'(o_rd_req), 32'd0);
    pop_n(32);
    chk("underflow_clear", 32'(o_underflow), 32'd0);
    pop_zero();
    chk("underflow_set", 32'(o_underflow), 32'd1);

    // Frame 2: abort a burst with vsync after three words.
    vs = 1'b0; tick(); vs = 1'b1;
    chk("underflow_sticky", 32'(o_underflow), 32'd1);
    wait_req(22'd0, "addr_f2_b0"); grant(2); fill(16'h2000); send(1'b0, 1'b0);
    wait_req(22'd8, "addr_f2_b1"); grant(2);
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      data  = 16'h3000 + 16'(i);
      if (i < 3) mq.push_back(data);
      vs = (i == 3) ? 1'b0 : 1'b1;
      pix_req = (i == 5) ? 1'b1 : 1'b0;
      if (i == 5) sb.push_back(30'd0);
      tick();
    end
    valid = 1'b0; pix_req = 1'b0; vs = 1'b1;
    mq.delete();
    wait_req(22'd0, "addr_rewind");
    pop_zero();
    chk("underflow_still_set", 32'(o_underflow), 32'd1);
    grant(1); fill(16'hFFF0); send(1'b0, 1'b0);
    pop_n(1);

    // Reset in the middle of a burst.
    wait_req(22'd8, "addr_pre_reset"); grant(1);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = 16'h4000 + 16'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(o_rd_req), 32'd0);
    chk("midrst_rgb", 32'({o_red, o_green, o_blue}), 32'd0);
    chk("midrst_underflow", 32'(o_underflow), 32'd0);
    chk("midrst_addr", 32'(o_rd_addr), 32'd0);
    valid = 1'b0;
    mq.delete();
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_wait_vs", 32'(o_rd_req), 32'd0);
    pop_zero();
    chk("post_rst_fifo_empty", 32'(o_underflow), 32'd1);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
